// File: rtl/l2sw_pkg.sv
// Shared types and constants for the L2 switch learning/lookup path.
package l2sw_pkg;

   localparam int unsigned MAC_WIDTH      = 48;
   localparam int unsigned MULTICAST_BIT  = 40;
   localparam int unsigned PORT_IDX_WIDTH = 3;

   localparam logic [MAC_WIDTH-1:0] BROADCAST_MAC = 48'hFFFF_FFFF_FFFF;

   typedef logic [MAC_WIDTH-1:0]      mac_t;
   typedef logic [PORT_IDX_WIDTH-1:0] port_idx_t;

   typedef enum logic [2:0] {
      StIdle,
      StSrcCmp,
      StLearn,
      StWrWait,
      StDstCmp,
      StResp,
      StFlush,
      StFlushWait
   } state_e;

   // Group addresses (multicast and broadcast) are never learned or looked up.
   function automatic logic is_group(input mac_t mac);
      return mac[MULTICAST_BIT] || (mac == BROADCAST_MAC);
   endfunction

endpackage

// File: rtl/mac_port_table.sv
// Egress-port table indexed by CAM address, with per-entry valid bits.
module mac_port_table #(
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned PORT_WIDTH = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [PORT_WIDTH-1:0] wr_port,
   input  logic                  clr_en,
   input  logic [ADDR_WIDTH-1:0] clr_addr,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [PORT_WIDTH-1:0] rd_port,
   output logic                  rd_valid
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [PORT_WIDTH-1:0] port_q [DEPTH];
   logic [DEPTH-1:0]      valid_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            port_q[i] <= '0;
         end
         valid_q <= '0;
      end else begin
         if (clr_en) begin
            valid_q[clr_addr] <= 1'b0;
         end
         if (wr_en) begin
            port_q[wr_addr]  <= wr_port;
            valid_q[wr_addr] <= 1'b1;
         end
      end
   end

   assign rd_port  = port_q[rd_addr];
   assign rd_valid = valid_q[rd_addr];

endmodule

// File: rtl/mac_learn_ctrl.sv
// Source-learn / destination-lookup sequencer in front of the switch CAM.
module mac_learn_ctrl
   import l2sw_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 5,
   parameter int unsigned PORT_WIDTH  = PORT_IDX_WIDTH,
   parameter int unsigned CAM_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [MAC_WIDTH-1:0]  req_src_mac,
   input  logic [MAC_WIDTH-1:0]  req_dst_mac,
   input  logic [PORT_WIDTH-1:0] req_port,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic                  resp_hit,
   output logic [PORT_WIDTH-1:0] resp_port,
   input  logic                  flush,
   output logic                  flush_busy,
   output logic [ADDR_WIDTH-1:0] cam_write_addr,
   output logic [MAC_WIDTH-1:0]  cam_write_data,
   output logic                  cam_write_delete,
   output logic                  cam_write_enable,
   input  logic                  cam_write_busy,
   output logic [MAC_WIDTH-1:0]  cam_compare_data,
   input  logic                  cam_match,
   input  logic [ADDR_WIDTH-1:0] cam_match_addr
);

   localparam logic [1:0]            LAT_LAST  = 2'(CAM_LATENCY - 1);
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

   state_e                state_q, state_d;
   mac_t                  src_q, src_d, dst_q, dst_d, cmp_q, cmp_d;
   logic [PORT_WIDTH-1:0] port_q, port_d, rport_q, rport_d;
   logic [ADDR_WIDTH-1:0] alloc_ptr_q, alloc_ptr_d, flush_addr_q, flush_addr_d;
   logic [1:0]            wait_cnt_q, wait_cnt_d;
   logic                  flush_pend_q, flush_pend_d, hit_q, hit_d;

   logic                  tbl_wr_en, tbl_clr_en, tbl_rd_valid;
   logic [ADDR_WIDTH-1:0] tbl_wr_addr;
   logic [PORT_WIDTH-1:0] tbl_rd_port;

   mac_port_table #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .PORT_WIDTH (PORT_WIDTH)
   ) u_port_table (
      .clk      (clk),
      .rst_n    (rst_n),
      .wr_en    (tbl_wr_en),
      .wr_addr  (tbl_wr_addr),
      .wr_port  (port_q),
      .clr_en   (tbl_clr_en),
      .clr_addr (flush_addr_q),
      .rd_addr  (cam_match_addr),
      .rd_port  (tbl_rd_port),
      .rd_valid (tbl_rd_valid)
   );

   always_comb begin
      state_d          = state_q;
      src_d            = src_q;
      dst_d            = dst_q;
      cmp_d            = cmp_q;
      port_d           = port_q;
      rport_d          = rport_q;
      hit_d            = hit_q;
      alloc_ptr_d      = alloc_ptr_q;
      flush_addr_d     = flush_addr_q;
      wait_cnt_d       = wait_cnt_q;
      flush_pend_d     = flush_pend_q | flush;
      req_ready        = 1'b0;
      cam_write_enable = 1'b0;
      cam_write_delete = 1'b0;
      cam_write_addr   = '0;
      cam_write_data   = '0;
      tbl_wr_en        = 1'b0;
      tbl_wr_addr      = alloc_ptr_q;
      tbl_clr_en       = 1'b0;

      unique case (state_q)
         StIdle: begin
            req_ready = !flush && !flush_pend_q && !cam_write_busy;
            if (flush || flush_pend_q) begin
               flush_pend_d = 1'b0;
               flush_addr_d = '0;
               state_d      = StFlush;
            end else if (req_valid && req_ready) begin
               src_d      = req_src_mac;
               dst_d      = req_dst_mac;
               port_d     = req_port;
               cmp_d      = req_src_mac;
               wait_cnt_d = '0;
               state_d    = StSrcCmp;
            end
         end
         StSrcCmp: begin
            if (wait_cnt_q == LAT_LAST) begin
               wait_cnt_d = '0;
               if (!is_group(src_q) && !cam_match) begin
                  state_d = StLearn;
               end else begin
                  // Known station: refresh its port (covers station moves).
                  tbl_wr_en   = !is_group(src_q);
                  tbl_wr_addr = cam_match_addr;
                  if (!is_group(dst_q)) cmp_d = dst_q;
                  state_d = StDstCmp;
               end
            end else begin
               wait_cnt_d = wait_cnt_q + 2'd1;
            end
         end
         StLearn: begin
            if (!cam_write_busy) begin
               cam_write_enable = 1'b1;
               cam_write_addr   = alloc_ptr_q;
               cam_write_data   = src_q;
               tbl_wr_en        = 1'b1;
               alloc_ptr_d      = alloc_ptr_q + 1'b1;
               state_d          = StWrWait;
            end
         end
         StWrWait: begin
            if (!cam_write_busy) begin
               if (!is_group(dst_q)) cmp_d = dst_q;
               state_d = StDstCmp;
            end
         end
         StDstCmp: begin
            if (is_group(dst_q)) begin
               hit_d   = 1'b0;
               rport_d = '0;
               state_d = StResp;
            end else if (wait_cnt_q == LAT_LAST) begin
               wait_cnt_d = '0;
               hit_d      = cam_match && tbl_rd_valid;
               rport_d    = (cam_match && tbl_rd_valid) ? tbl_rd_port : '0;
               state_d    = StResp;
            end else begin
               wait_cnt_d = wait_cnt_q + 2'd1;
            end
         end
         StResp: begin
            if (resp_ready) state_d = StIdle;
         end
         StFlush: begin
            if (!cam_write_busy) begin
               cam_write_enable = 1'b1;
               cam_write_delete = 1'b1;
               cam_write_addr   = flush_addr_q;
               tbl_clr_en       = 1'b1;
               state_d          = StFlushWait;
            end
         end
         StFlushWait: begin
            if (!cam_write_busy) begin
               if (flush_addr_q == LAST_ADDR) begin
                  alloc_ptr_d = '0;
                  state_d     = StIdle;
               end else begin
                  flush_addr_d = flush_addr_q + 1'b1;
                  state_d      = StFlush;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         src_q        <= '0;
         dst_q        <= '0;
         cmp_q        <= '0;
         port_q       <= '0;
         rport_q      <= '0;
         hit_q        <= 1'b0;
         alloc_ptr_q  <= '0;
         flush_addr_q <= '0;
         wait_cnt_q   <= '0;
         flush_pend_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         src_q        <= src_d;
         dst_q        <= dst_d;
         cmp_q        <= cmp_d;
         port_q       <= port_d;
         rport_q      <= rport_d;
         hit_q        <= hit_d;
         alloc_ptr_q  <= alloc_ptr_d;
         flush_addr_q <= flush_addr_d;
         wait_cnt_q   <= wait_cnt_d;
         flush_pend_q <= flush_pend_d;
      end
   end

   assign cam_compare_data = cmp_q;
   assign resp_valid       = (state_q == StResp);
   assign resp_hit         = hit_q;
   assign resp_port        = rport_q;
   assign flush_busy       = flush_pend_q || (state_q == StFlush) || (state_q == StFlushWait);

endmodule

// File: tb/tb_mac_learn_ctrl.sv
// Directed bench for mac_learn_ctrl against a small behavioural CAM model.
module tb_mac_learn_ctrl;
   import l2sw_pkg::*;

   localparam int unsigned AW       = 5;
   localparam int unsigned PW       = 3;
   localparam int unsigned LAT      = 1;
   localparam int          BUSY_CYC = 2;

   logic          clk, rst_n;
   logic          req_valid, req_ready, resp_valid, resp_ready, resp_hit;
   logic [47:0]   req_src_mac, req_dst_mac;
   logic [PW-1:0] req_port, resp_port;
   logic          flush, flush_busy;
   logic [AW-1:0] cam_write_addr, cam_match_addr;
   logic [47:0]   cam_write_data, cam_compare_data;
   logic          cam_write_delete, cam_write_enable, cam_write_busy, cam_match;

   mac_learn_ctrl #(
      .ADDR_WIDTH  (AW),
      .PORT_WIDTH  (PW),
      .CAM_LATENCY (LAT)
   ) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_src_mac      (req_src_mac),
      .req_dst_mac      (req_dst_mac),
      .req_port         (req_port),
      .resp_valid       (resp_valid),
      .resp_ready       (resp_ready),
      .resp_hit         (resp_hit),
      .resp_port        (resp_port),
      .flush            (flush),
      .flush_busy       (flush_busy),
      .cam_write_addr   (cam_write_addr),
      .cam_write_data   (cam_write_data),
      .cam_write_delete (cam_write_delete),
      .cam_write_enable (cam_write_enable),
      .cam_write_busy   (cam_write_busy),
      .cam_compare_data (cam_compare_data),
      .cam_match        (cam_match),
      .cam_match_addr   (cam_match_addr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // CAM model: lookup settles within the cycle, writes take BUSY_CYC busy cycles.
   logic [47:0] cam_mac [32];
   logic [31:0] cam_vld;
   int          busy_cnt;

   always @(posedge clk) begin
      if (!rst_n) begin
         cam_vld  <= '0;
         busy_cnt <= 0;
      end else begin
         if (cam_write_enable) begin
            if (cam_write_delete) begin
               cam_vld[cam_write_addr] <= 1'b0;
            end else begin
               cam_mac[cam_write_addr] <= cam_write_data;
               cam_vld[cam_write_addr] <= 1'b1;
            end
         end
         busy_cnt <= cam_write_enable ? BUSY_CYC : ((busy_cnt > 0) ? busy_cnt - 1 : 0);
      end
   end

   assign cam_write_busy = (busy_cnt != 0);

   always_comb begin
      cam_match      = 1'b0;
      cam_match_addr = '0;
      for (int i = 31; i >= 0; i--) begin
         if (cam_vld[i] && cam_mac[i] == cam_compare_data) begin
            cam_match      = 1'b1;
            cam_match_addr = 5'(i);
         end
      end
   end

   int wr_cnt = 0, wr_last = -1, del_cnt = 0, del_next = 0;
   int del_order_err = 0, del_fb_err = 0, en_busy_err = 0, watch_hits = 0;
   logic [47:0] watch_mac = 48'hDEAD_BEEF_0000;

   always @(posedge clk) begin
      if (cam_write_enable) begin
         wr_cnt++;
         wr_last = int'(cam_write_addr);
         if (cam_write_busy) en_busy_err++;
         if (cam_write_delete) begin
            del_cnt++;
            if (int'(cam_write_addr) != del_next % 32) del_order_err++;
            del_next++;
            if (!flush_busy) del_fb_err++;
         end
      end
   end

   always @(negedge clk) begin
      if (cam_compare_data == watch_mac) watch_hits++;
   end

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [47:0] m(input int n);
      return 48'h0200_0000_0000 | 48'(n);
   endfunction

   task automatic do_req(input logic [47:0] src, input logic [47:0] dst, input logic [PW-1:0] port,
                         input int hold, output logic hit, output logic [PW-1:0] rp,
                         output int lat);
      int n;
      int w0;
      @(negedge clk);
      req_valid   = 1'b1;
      req_src_mac = src;
      req_dst_mac = dst;
      req_port    = port;
      resp_ready  = (hold == 0);
      n = 0;
      while (!req_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) check("req_ready_timeout", 0, 1);
      @(negedge clk);
      req_valid = 1'b0;
      n = 1;
      while (!resp_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!resp_valid) check("resp_valid_timeout", 0, 1);
      lat = n;
      hit = resp_hit;
      rp  = resp_port;
      if (hold > 0) begin
         w0 = wr_cnt;
         repeat (hold) begin
            @(negedge clk);
            check("hold_valid", resp_valid, 1);
            check("hold_hit", resp_hit, hit);
            check("hold_port", resp_port, rp);
            check("hold_req_ready", req_ready, 0);
         end
         check("hold_no_write", wr_cnt - w0, 0);
         resp_ready = 1'b1;
      end
      @(negedge clk);
      check("resp_drop", resp_valid, 0);
      resp_ready = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic          h;
      logic [PW-1:0] p;
      int            lat, w0, wh0, d0, n;

      rst_n = 1'b0; req_valid = 1'b0; resp_ready = 1'b0; flush = 1'b0;
      req_src_mac = '0; req_dst_mac = '0; req_port = '0;
      repeat (3) @(negedge clk);
      check("rst_resp_valid", resp_valid, 0);
      check("rst_write_en", cam_write_enable, 0);
      check("rst_flush_busy", flush_busy, 0);
      check("rst_resp_hit", resp_hit, 0);
      check("rst_compare", cam_compare_data, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_reset", req_ready, 1);

      // First learn: allocated at address 0, destination unknown.
      w0 = wr_cnt;
      do_req(m(1), m(2), 3'd3, 0, h, p, lat);
      check("t1_writes", wr_cnt - w0, 1);
      check("t1_addr", wr_last, 0);
      check("t1_hit", h, 0);
      check("t1_port", p, 0);

      w0 = wr_cnt;
      do_req(m(2), m(1), 3'd5, 0, h, p, lat);
      check("t2_writes", wr_cnt - w0, 1);
      check("t2_addr", wr_last, 1);
      check("t2_hit", h, 1);
      check("t2_port", p, 3);

      // Station move: m1 re-appears on port 6.
      w0 = wr_cnt;
      do_req(m(1), m(3), 3'd6, 0, h, p, lat);
      check("move_writes", wr_cnt - w0, 0);
      check("move_hit", h, 0);
      do_req(m(2), m(1), 3'd5, 0, h, p, lat);
      check("move_lookup_hit", h, 1);
      check("move_lookup_port", p, 6);
      check("hit_latency", lat, 2 * LAT + 1);

      // Group destinations never reach the compare port.
      watch_mac = BROADCAST_MAC;
      wh0 = watch_hits;
      do_req(m(2), BROADCAST_MAC, 3'd5, 0, h, p, lat);
      check("bcast_hit", h, 0);
      check("bcast_port", p, 0);
      check("bcast_no_cmp", watch_hits - wh0, 0);
      watch_mac = 48'h0100_5E00_0001;
      wh0 = watch_hits;
      do_req(m(2), 48'h0100_5E00_0001, 3'd5, 0, h, p, lat);
      check("mcast_hit", h, 0);
      check("mcast_no_cmp", watch_hits - wh0, 0);
      watch_mac = 48'hDEAD_BEEF_0000;
      w0 = wr_cnt;
      do_req(48'h0100_5E00_0007, m(1), 3'd2, 0, h, p, lat);
      check("mcast_src_no_write", wr_cnt - w0, 0);
      check("mcast_src_hit", h, 1);
      check("mcast_src_port", p, 6);

      // Back-pressure on the response.
      do_req(m(2), m(1), 3'd5, 10, h, p, lat);
      check("hold_final_hit", h, 1);
      check("hold_final_port", p, 6);

      // Four entries, then flush.
      do_req(m(3), m(1), 3'd1, 0, h, p, lat);
      check("l3_addr", wr_last, 2);
      do_req(m(4), m(3), 3'd2, 0, h, p, lat);
      check("l4_addr", wr_last, 3);
      check("l4_hit", h, 1);
      check("l4_port", p, 1);
      d0 = del_cnt;
      @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check("flush_busy_start", flush_busy, 1);
      n = 0;
      while (flush_busy && n < 1000) begin
         @(negedge clk);
         n++;
      end
      check("flush_done", flush_busy, 0);
      check("flush_deletes", del_cnt - d0, 32);
      check("flush_order", del_order_err, 0);
      check("flush_busy_during", del_fb_err, 0);
      w0 = wr_cnt;
      do_req(m(9), m(1), 3'd4, 0, h, p, lat);
      check("post_flush_miss", h, 0);
      check("post_flush_writes", wr_cnt - w0, 1);
      check("post_flush_addr", wr_last, 0);

      // Fill the rest of the table, then wrap and evict the oldest (m9 at address 0).
      for (int i = 1; i < 32; i++) begin
         do_req(m(100 + i), m(9), PW'(i % 8), 0, h, p, lat);
         check("fill_addr", wr_last, i);
      end
      do_req(m(200), m(9), 3'd7, 0, h, p, lat);
      check("wrap_addr", wr_last, 0);
      check("wrap_evicted_in_txn", h, 0);
      do_req(m(101), m(9), 3'd1, 0, h, p, lat);
      check("wrap_first_miss", h, 0);
      do_req(m(101), m(200), 3'd1, 0, h, p, lat);
      check("wrap_new_hit", h, 1);
      check("wrap_new_port", p, 7);

      check("no_write_while_busy", en_busy_err, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
